// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the 7-segment display scanner.
// The optional LEADING_ZERO_BLANK_EN feature lives in seg_display_scanner.sv.
package seg_disp_pkg;

  localparam int MAX_NDIG = 32;

  localparam logic [3:0]          BLANK_CODE = 4'hF;
  localparam logic [MAX_NDIG-1:0] AN_ALL_OFF = '1;

  // Active-low one-hot anode pattern; callers truncate to their digit count.
  function automatic logic [MAX_NDIG-1:0] onehot_n(input int unsigned idx);
    return ~(MAX_NDIG'(1) << idx);
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Slot-rate prescaler: counts 0..DIV-1 while enabled and holds its count when not.
// tick is combinational at the terminal count and only while en is high.
module refresh_prescaler
  import seg_disp_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == CW'(DIV - 1));
    cnt_d = cnt_q;
    if (tick)    cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexes NDIG packed BCD digits onto one shared 7-segment decoder.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is never blanked).
module seg_display_scanner
  import seg_disp_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int IWL         = 4,
  parameter int REFRESH_DIV = 100000,
  localparam int IDXW       = clog2(NDIG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [IWL*NDIG-1:0] digits,
  output logic [IWL-1:0]      bcd_out,
  output logic [NDIG-1:0]     an,
  output logic [IDXW-1:0]     digit_idx,
  output logic                frame_tick
);

  logic                slot_tick;
  logic [IDXW-1:0]     idx_q, idx_d, next_idx;
  logic [NDIG-1:0]     an_q, an_d;
  logic [IWL-1:0]      bcd_q, bcd_d, code;
  logic                ft_q, ft_d;
  logic [IWL*NDIG-1:0] shadow_q, shadow_d, src;
  logic                frame_edge, blank;

  refresh_prescaler #(.DIV(REFRESH_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (slot_tick)
  );

  always_comb begin
    next_idx   = (idx_q == IDXW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    frame_edge = (next_idx == '0);
    // Digit 0 comes from the live input so it matches the value being captured.
    src        = frame_edge ? digits : shadow_q;
    code       = src[IWL*next_idx +: IWL];
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic upper_nz;
      upper_nz = 1'b0;
      for (int k = 0; k < NDIG; k++) begin
        if (IDXW'(k) >= next_idx && src[IWL*k +: IWL] != '0) upper_nz = 1'b1;
      end
      blank = !frame_edge && !upper_nz;
    end
`else
    blank = 1'b0;
`endif

    idx_d    = idx_q;
    an_d     = an_q;
    bcd_d    = bcd_q;
    ft_d     = 1'b0;
    shadow_d = shadow_q;
    if (!en) begin
      an_d  = NDIG'(AN_ALL_OFF);
      bcd_d = IWL'(BLANK_CODE);
    end else if (slot_tick) begin
      idx_d = next_idx;
      an_d  = NDIG'(onehot_n(32'(next_idx)));
      bcd_d = blank ? IWL'(BLANK_CODE) : code;
      if (frame_edge) begin
        shadow_d = digits;
        ft_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= IDXW'(NDIG - 1);
      an_q     <= NDIG'(AN_ALL_OFF);
      bcd_q    <= IWL'(BLANK_CODE);
      ft_q     <= 1'b0;
      shadow_q <= '0;
    end else begin
      idx_q    <= idx_d;
      an_q     <= an_d;
      bcd_q    <= bcd_d;
      ft_q     <= ft_d;
      shadow_q <= shadow_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with NDIG=4, REFRESH_DIV=4.
// Build with LEADING_ZERO_BLANK_EN defined to select the blanking expectations.
module tb_seg_display_scanner;

  localparam int NDIG = 4;
  localparam int IWL  = 4;
  localparam int DIV  = 4;

  logic                clk;
  logic                rst;
  logic                en;
  logic [IWL*NDIG-1:0] digits;
  logic [IWL-1:0]      bcd_out;
  logic [NDIG-1:0]     an;
  logic [1:0]          digit_idx;
  logic                frame_tick;

  int n_pass = 0;
  int n_chk  = 0;

  seg_display_scanner #(.NDIG(NDIG), .IWL(IWL), .REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits     (digits),
    .bcd_out    (bcd_out),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_slot(input string tag, input logic [3:0] exp_an, input logic [3:0] exp_bcd,
                          input logic exp_ft);
    chk({tag, "_an"},  32'(an),         32'(exp_an));
    chk({tag, "_bcd"}, 32'(bcd_out),    32'(exp_bcd));
    chk({tag, "_ft"},  32'(frame_tick), 32'(exp_ft));
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    digits = '0;
    #2;
    chk("rst_an",  32'(an),         32'hF);
    chk("rst_bcd", 32'(bcd_out),    32'hF);
    chk("rst_idx", 32'(digit_idx),  32'd3);
    chk("rst_ft",  32'(frame_tick), 32'd0);

    // scan 16'h1234
    step(2);
    rst    = 1'b0;
    en     = 1'b1;
    digits = 16'h1234;
    step(3);
    chk_slot("dark", 4'b1111, 4'hF, 1'b0);
    step(1);
    chk_slot("s0", 4'b1110, 4'h4, 1'b1);
    chk("s0_idx", 32'(digit_idx), 32'd0);
    step(1);
    chk_slot("s0_hold", 4'b1110, 4'h4, 1'b0);
    step(3);
    chk_slot("s1", 4'b1101, 4'h3, 1'b0);
    step(4);
    chk_slot("s2", 4'b1011, 4'h2, 1'b0);

    // change mid-frame: digit 3 still shows the old frame
    digits = 16'h5678;
    step(4);
    chk_slot("tear3", 4'b0111, 4'h1, 1'b0);
    step(4);
    chk_slot("nf0", 4'b1110, 4'h8, 1'b1);
    step(4);
    chk_slot("nf1", 4'b1101, 4'h7, 1'b0);
    step(4);
    chk_slot("nf2", 4'b1011, 4'h6, 1'b0);
    step(4);
    chk_slot("nf3", 4'b0111, 4'h5, 1'b0);
    chk("nf3_idx", 32'(digit_idx), 32'd3);

    // enable drop mid-slot: prescaler held at 2
    step(2);
    en = 1'b0;
    step(1);
    chk_slot("en_off", 4'b1111, 4'hF, 1'b0);
    step(9);
    chk_slot("en_off9", 4'b1111, 4'hF, 1'b0);
    chk("en_off_idx", 32'(digit_idx), 32'd3);
    en = 1'b1;
    step(1);
    chk_slot("en_resume", 4'b1111, 4'hF, 1'b0);
    step(1);
    chk_slot("en_next", 4'b1110, 4'h8, 1'b1);

    // invalid codes and wrap
    digits = 16'hFA09;
    step(4);
    chk("inv_old1", 32'(bcd_out), 32'h7);
    step(8);
    chk("inv_old3", 32'(bcd_out), 32'h5);
    step(4);
    chk_slot("inv0", 4'b1110, 4'h9, 1'b1);
    step(4);
    chk_slot("inv1", 4'b1101, 4'h0, 1'b0);
    step(4);
    chk_slot("inv2", 4'b1011, 4'hA, 1'b0);
    step(4);
    chk_slot("inv3", 4'b0111, 4'hF, 1'b0);
    step(4);
    chk_slot("wrap0", 4'b1110, 4'h9, 1'b1);
    chk("wrap_idx", 32'(digit_idx), 32'd0);

    // leading zeros: 16'h0050 (shadow still FA09 for the rest of this frame)
    digits = 16'h0050;
    step(12);
    chk("lz_old3", 32'(bcd_out), 32'hF);
    step(4);
    chk_slot("lz50_0", 4'b1110, 4'h0, 1'b1);
    step(4);
    chk_slot("lz50_1", 4'b1101, 4'h5, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
    step(4);
    chk_slot("lz50_2", 4'b1011, 4'hF, 1'b0);
    step(4);
    chk_slot("lz50_3", 4'b0111, 4'hF, 1'b0);
`else
    step(4);
    chk_slot("lz50_2", 4'b1011, 4'h0, 1'b0);
    step(4);
    chk_slot("lz50_3", 4'b0111, 4'h0, 1'b0);
`endif

    digits = 16'h0000;
    step(4);
    chk_slot("lz00_0", 4'b1110, 4'h0, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    step(4);
    chk_slot("lz00_1", 4'b1101, 4'hF, 1'b0);
    step(4);
    chk_slot("lz00_2", 4'b1011, 4'hF, 1'b0);
`else
    step(4);
    chk_slot("lz00_1", 4'b1101, 4'h0, 1'b0);
    step(4);
    chk_slot("lz00_2", 4'b1011, 4'h0, 1'b0);
`endif

    // asynchronous reset mid-slot, checked before the next edge
    step(1);
    rst = 1'b1;
    #1;
    chk("arst_an",  32'(an),         32'hF);
    chk("arst_bcd", 32'(bcd_out),    32'hF);
    chk("arst_idx", 32'(digit_idx),  32'd3);
    chk("arst_ft",  32'(frame_tick), 32'd0);
    step(2);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
